load_store_unit: RTL
====================

# load_store_unit

Memory-access stage between the CPU execute stage and the 32-bit word-addressed data memory (byte write enables, 1-cycle synchronous read). Converts byte-addressed RISC-V loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses. Generates the write-enable mask and lane-shifted store data, and realigns and sign/zero-extends load data. Accesses that cross a word boundary are split into two sequential word accesses.

## Interface
- WORD_ADDR_W, 15, data-memory word-address width; byte space is 2^(WORD_ADDR_W+2) bytes (128 KiB).
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V size/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle pulse: load data or store completion
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; illegal funct3 or out-of-range access
- mem_we  out  4  byte write enables to data memory
- mem_r_addr  out  WORD_ADDR_W  read word address
- mem_w_addr  out  WORD_ADDR_W  write word address
- mem_w_data  out  32  lane-aligned write data
- mem_r_data  in  32  read data, valid the cycle after mem_r_addr is presented

## Operation
- Accept: req_valid && req_ready. req_ready = (state == IDLE).
- Legal funct3:
  - loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores 000, 001, 010;
  - everything else is illegal.
- Decode: off = addr[1:0]; W = addr[16:2]; size = 1/2/4 bytes. Split when off + size > 4.
- Error: illegal funct3, addr[31:17] != 0, or a split whose W+1 exceeds the word range (no wrap).
  - On error: no memory write; resp_err = 1, resp_rdata = 0.
- Store masks and data:
  - lo mask = (size mask 0001/0011/1111 << off)[3:0]; lo data = wdata << 8*off.
  - hi mask = (size mask << off)[7:4]; hi data = wdata >> 8*(4-off).
- Load merge: merged = (lo >> 8*off) | (hi << 8*(4-off)). For unsplit loads, hi = 0.
  - Truncate merged to size, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- States:
  - IDLE
  - LD_WAIT: aligned load, data arriving
  - LD_LO: split load, lo word arriving, hi read issued
  - LD_HI: hi word arriving
  - ST_HI: second store write
- Transitions:
  - IDLE → LD_WAIT on unsplit load; IDLE → LD_LO on split load; IDLE → ST_HI on split store.
  - Unsplit store and error stay in IDLE.
  - LD_WAIT → IDLE. LD_LO → LD_HI. LD_HI → IDLE. ST_HI → IDLE.
- Memory drive:
  - mem_r_addr = W in IDLE, W+1 in LD_LO.
  - mem_we = lo mask only in IDLE on an accepted legal store; hi mask only in ST_HI; 0 otherwise.
  - mem_w_addr and mem_w_data follow the same phase.
- Registered per request: W, off, funct3, hi mask/data, and the lo word (captured in LD_LO).
- No response backpressure: the consumer always takes resp_valid.

## Timing
- T = accept cycle. Memory address and enables for the first access are combinational in T.
- Unsplit store: write at T; resp_valid at T+1; next request can be accepted at T+1 (one store per cycle).
- Split store: lo write at T, hi write at T+1; resp_valid at T+2; req_ready = 0 at T+1.
- Unsplit load: read issued at T; data registered at end of T+1; resp_valid at T+2.
- Split load: lo issued at T, hi issued at T+1; resp_valid at T+3.
- Error: resp_valid and resp_err at T+1; state stays IDLE.
- resp_valid, resp_err and resp_rdata are registered; resp_valid is high for exactly one cycle per request.
- Reset (rst_n low at a clock edge): state = IDLE, resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - While rst_n is low: mem_we = 0 and req_ready = 0.
- Reset mid-operation: the pending hi write/read is abandoned (no hi write) and no response is produced. The lo write of a split store, already done, stays.
- req_valid during a non-IDLE state is ignored; the request must be held until accepted.

## Test plan
- SW 0xDEADBEEF @0x100, then LW @0x100 → mem_we = 1111, w_addr 0x40, w_data 0xDEADBEEF at T; load gives resp_rdata 0xDEADBEEF at T+2, resp_err 0.
- SB 0x80 @0x103 → mem_we = 1000, w_data 0x80000000. Then LB @0x103 → 0xFFFFFF80; LBU @0x103 → 0x00000080.
- Split SW 0x11223344 @0x102:
  - T: we = 1100, w_addr 0x40, data 0x33440000.
  - T+1: we = 0011, w_addr 0x41, data 0x00001122; resp_valid at T+2.
  - LW @0x102 → 0x11223344 at T+3; LH @0x103 → 0x00002233.
- Errors (each: resp_err = 1 at T+1, mem_we = 0 throughout):
  - LW @0x20000
  - store with funct3 = 011
  - SW @0x1FFFE (split past the top word)
- Assert rst_n = 0 during ST_HI of a split SW → hi word unchanged, no resp_valid; after release, req_ready = 1 and a new LW completes normally.
- Four back-to-back SWs with req_valid held, addresses 0x0, 0x4, 0x8, 0xC → accepted on consecutive cycles, four resp_valid pulses T+1..T+4.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: steers byte-addressed loads/stores onto a word-addressed data memory,
// extends load data and splits word-crossing accesses into two sequential word accesses.
module load_store_unit #(
    parameter int unsigned WORD_ADDR_W = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_store,
    input  logic [2:0]             req_funct3,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   resp_valid,
    output logic [31:0]            resp_rdata,
    output logic                   resp_err,
    output logic [3:0]             mem_we,
    output logic [WORD_ADDR_W-1:0] mem_r_addr,
    output logic [WORD_ADDR_W-1:0] mem_w_addr,
    output logic [31:0]            mem_w_data,
    input  logic [31:0]            mem_r_data
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LD_WAIT = 3'd1;
    localparam logic [2:0] LD_LO   = 3'd2;
    localparam logic [2:0] LD_HI   = 3'd3;
    localparam logic [2:0] ST_HI   = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [WORD_ADDR_W-1:0] w_q, w_inc;
    logic [1:0]             off_q;
    logic [2:0]             funct3_q;
    logic [3:0]             hi_mask_q;
    logic [31:0]            hi_data_q, lo_word_q;

    logic [1:0]             off;
    logic [WORD_ADDR_W-1:0] word;
    logic [2:0]             size;
    logic [3:0]             size_mask;
    logic                   legal, split, range_err, err, accept;
    logic [7:0]             mask_wide;
    logic [63:0]            data_wide;
    logic [31:0]            ld_lo, ld_hi, merged, load_ext;
    logic [5:0]             ld_shift;

    always_comb begin
        off  = req_addr[1:0];
        word = req_addr[WORD_ADDR_W+1:2];
        case (req_funct3[1:0])
            2'b00:   begin size = 3'd1; size_mask = 4'b0001; end
            2'b01:   begin size = 3'd2; size_mask = 4'b0011; end
            2'b10:   begin size = 3'd4; size_mask = 4'b1111; end
            default: begin size = 3'd4; size_mask = 4'b0000; end
        endcase
        // Unsigned forms (funct3[2]) exist only for loads of bytes/halves.
        legal = (req_funct3[1:0] != 2'b11) &&
                (!req_funct3[2] || (!req_store && req_funct3[1:0] != 2'b10));
        split     = ({1'b0, off} + size) > 3'd4;
        range_err = |req_addr[31:WORD_ADDR_W+2];
        err       = !legal || range_err || (split && (&word));
        mask_wide = {4'b0000, size_mask} << off;
        data_wide = {32'b0, req_wdata} << {off, 3'b000};
        req_ready = rst_n && (state_q == IDLE);
        accept    = req_valid && req_ready;
        w_inc     = w_q + WORD_ADDR_W'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !err) begin
                    if (req_store) state_d = split ? ST_HI : IDLE;
                    else           state_d = split ? LD_LO : LD_WAIT;
                end
            end
            LD_LO:   state_d = LD_HI;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_r_addr = (state_q == LD_LO) ? w_inc : word;
        mem_w_addr = (state_q == ST_HI) ? w_inc : word;
        mem_w_data = (state_q == ST_HI) ? hi_data_q : data_wide[31:0];
        mem_we     = 4'b0000;
        if (accept && req_store && !err) begin
            mem_we = mask_wide[3:0];
        end else if (rst_n && state_q == ST_HI) begin
            mem_we = hi_mask_q;
        end
    end

    always_comb begin
        ld_lo    = (state_q == LD_HI) ? lo_word_q : mem_r_data;
        ld_hi    = (state_q == LD_HI) ? mem_r_data : 32'b0;
        ld_shift = 6'd32 - {1'b0, off_q, 3'b000};
        // A zero offset shifts the hi word fully out.
        merged   = (ld_lo >> {off_q, 3'b000}) | (ld_hi << ld_shift);
        case (funct3_q)
            3'b000:  load_ext = {{24{merged[7]}}, merged[7:0]};
            3'b001:  load_ext = {{16{merged[15]}}, merged[15:0]};
            3'b100:  load_ext = {24'b0, merged[7:0]};
            3'b101:  load_ext = {16'b0, merged[15:0]};
            default: load_ext = merged;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'b0;
            w_q        <= '0;
            off_q      <= 2'b00;
            funct3_q   <= 3'b000;
            hi_mask_q  <= 4'b0000;
            hi_data_q  <= 32'b0;
            lo_word_q  <= 32'b0;
        end else begin
            state_q    <= state_d;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'b0;
            if (accept) begin
                w_q       <= word;
                off_q     <= off;
                funct3_q  <= req_funct3;
                hi_mask_q <= mask_wide[7:4];
                hi_data_q <= data_wide[63:32];
                if (err || (req_store && !split)) begin
                    resp_valid <= 1'b1;
                    resp_err   <= err;
                end
            end
            case (state_q)
                LD_WAIT, LD_HI: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= load_ext;
                end
                LD_LO:   lo_word_q <= mem_r_data;
                ST_HI:   resp_valid <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule
